// File: rtl/paralelo_serie_pkg.sv
// ---------------------------------------------------------------------------
// paralelo_serie_pkg
// Definitions shared by the parallel-to-serial transmitter (paralelo_serie)
// and its matching receiver (serial_paralelo):
//   - default idle/comma byte and default sync preamble length
//   - link state encoding (SYNC while the preamble is sent, RUN afterwards)
// ---------------------------------------------------------------------------
package paralelo_serie_pkg;

    // Idle/comma byte sent whenever no valid data is available.
    localparam logic [7:0]  BC_WORD_DEFAULT    = 8'hBC;

    // Number of comma bytes in the preamble that follows reset.
    localparam int unsigned SYNC_COUNT_DEFAULT = 4;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } link_state_e;

endpackage : paralelo_serie_pkg

// File: rtl/paralelo_serie.sv
// ---------------------------------------------------------------------------
// paralelo_serie
// Parallel-to-serial transmitter. One byte is loaded every 8 bit-clock
// cycles and shifted out MSB first. After reset a preamble of SYNC_COUNT
// comma bytes (BC_WORD) is sent before upstream data is accepted; once
// running, BC_WORD fills every slot without valid data.
//
// Parameters
//   BC_WORD     idle/comma byte
//   SYNC_COUNT  comma bytes in the post-reset preamble (must be >= 1)
//
// Ports
//   clk_32f    in   1  bit-rate clock, all state updates on rising edge
//   reset_L    in   1  asynchronous active-low reset
//   data_in    in   8  parallel byte, sampled only on a load edge
//   valid_in   in   1  data_in is valid, sampled only on a load edge
//   data_out   out  1  serial bit stream, MSB first
//   load       out  1  high when the next rising edge samples data_in/valid_in
//   bit_cnt    out  3  index of the bit currently on data_out (0 = MSB)
//   tx_active  out  1  preamble committed; upstream may present data
// ---------------------------------------------------------------------------
module paralelo_serie
    import paralelo_serie_pkg::*;
#(
    parameter logic [7:0]  BC_WORD    = BC_WORD_DEFAULT,
    parameter int unsigned SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       load,
    output logic [2:0] bit_cnt,
    output logic       tx_active
);

    localparam int CNT_W = $clog2(SYNC_COUNT + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_COUNT);

    link_state_e      state;
    link_state_e      state_next;
    logic [CNT_W-1:0] sync_cnt;
    logic [CNT_W-1:0] sync_cnt_next;
    logic [7:0]       byte_next;
    logic [7:0]       shift_reg;

    // Preamble counter never runs past the preamble length.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= SYNC_LAST) begin
            return SYNC_LAST;
        end
        return v + CNT_W'(1);
    endfunction

    // bit_cnt resets to 7 so the first edge after reset is a load edge.
    assign load      = (bit_cnt == 3'd7);
    assign data_out  = shift_reg[7];
    assign tx_active = (state == RUN);

    // ---- FSM state register ----
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state    <= SYNC;
            sync_cnt <= '0;
        end else begin
            state    <= state_next;
            sync_cnt <= sync_cnt_next;
        end
    end

    // ---- FSM next state and byte selection ----
    // byte_next only matters on load edges; outside them it is ignored.
    always_comb begin
        state_next    = state;
        sync_cnt_next = sync_cnt;
        byte_next     = BC_WORD;
        case (state)
            SYNC: begin
                // data_in is dropped during the preamble regardless of valid_in
                if (load) begin
                    sync_cnt_next = sat_inc(sync_cnt);
                    if (sat_inc(sync_cnt) == SYNC_LAST) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // A valid byte equal to BC_WORD goes out unchanged.
                if (valid_in) begin
                    byte_next = data_in;
                end
            end
            default: begin
                state_next = SYNC;
            end
        endcase
    end

    // ---- bit counter and shift register ----
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            bit_cnt   <= 3'd7;
            shift_reg <= '0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (load) begin
                shift_reg <= byte_next;
            end else begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
        end
    end

endmodule : paralelo_serie

// File: tb/tb_paralelo_serie.sv
// ---------------------------------------------------------------------------
// tb_paralelo_serie
// Bench for paralelo_serie. A byte-level model decides, at every load edge,
// which byte must go out; it is queued and compared once the 8 serial bits
// have been collected from data_out. Per-cycle checks cover load, bit_cnt
// and tx_active, including the edge on which tx_active first rises.
// ---------------------------------------------------------------------------
module tb_paralelo_serie;

    localparam logic [7:0]  BC = 8'hBC;
    localparam int unsigned SC = 4;

    logic       clk_32f;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       load;
    logic [2:0] bit_cnt;
    logic       tx_active;

    paralelo_serie dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .load      (load),
        .bit_cnt   (bit_cnt),
        .tx_active (tx_active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    int         total;
    int         bad;
    logic [2:0] ph;
    int         loads;
    int         edge_n;
    logic       tx_prev;
    logic [7:0] rx;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph      = 3'd7;
        loads   = 0;
        edge_n  = 0;
        tx_prev = 1'b0;
        rx      = 8'h00;
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_data_out"},  32'(data_out),  32'd0);
        chk({tag, "_tx_active"}, 32'(tx_active), 32'd0);
        chk({tag, "_bit_cnt"},   32'(bit_cnt),   32'd7);
        chk({tag, "_load"},      32'(load),      32'd1);
    endtask

    // One bit-clock cycle: drive inputs, let the edge happen, sample #1 later.
    task automatic cycle(input logic v, input logic [7:0] d);
        logic [7:0] e;
        chk("load", 32'(load), 32'(ph == 3'd7));
        valid_in = v;
        data_in  = d;
        if (ph == 3'd7) begin
            exp_q.push_back((loads < int'(SC) || !v) ? BC : d);
            loads++;
        end
        @(posedge clk_32f);
        #1;
        edge_n++;
        ph = ph + 3'd1;
        chk("bit_cnt", 32'(bit_cnt), 32'(ph));
        chk("tx_active", 32'(tx_active), 32'(loads >= int'(SC)));
        if (tx_active && !tx_prev) begin
            chk("tx_rise_edge", 32'(edge_n), 32'd25);
        end
        tx_prev = tx_active;
        rx = {rx[6:0], data_out};
        if (ph == 3'd7) begin
            chk("q_size", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("byte", 32'(rx), 32'(e));
            end
        end
    endtask

    // Eight cycles starting at a load edge; with noisy set, the inputs
    // toggle on the non-load edges and only the load-edge values count.
    task automatic send_byte(input logic v, input logic [7:0] d, input bit noisy);
        logic rv;
        for (int i = 0; i < 8; i++) begin
            if (ph == 3'd7 || !noisy) begin
                cycle(v, d);
            end else begin
                rv = 1'($urandom_range(0, 1));
                cycle(rv, (i % 2 == 1) ? 8'hFF : 8'h00);
            end
        end
    endtask

    initial begin
        logic       rv;
        logic [7:0] rd;
        total    = 0;
        bad      = 0;
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        model_reset();

        repeat (2) @(posedge clk_32f);
        #1;
        check_reset_state("rst0");
        reset_L = 1'b1;

        // Preamble with valid 0xFF offered: only commas may go out.
        repeat (4) send_byte(1'b1, 8'hFF, 1'b0);

        // Single data byte, then idle.
        send_byte(1'b1, 8'hA5, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);

        // Inputs toggling between load edges.
        repeat (2) send_byte(1'b1, 8'h3C, 1'b1);

        // Data equal to the comma byte passes unchanged.
        send_byte(1'b1, BC, 1'b0);

        // Back-to-back sequence 0x01..0x10.
        for (int i = 1; i <= 16; i++) send_byte(1'b1, 8'(i), 1'b0);

        // Random valid/data with noise between load edges.
        repeat (8) begin
            rv = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            send_byte(rv, rd, 1'b1);
        end

        // Reset asserted mid-byte at bit_cnt == 3 while running.
        repeat (4) cycle(1'b1, 8'h5A);
        chk("mid_bit_cnt", 32'(bit_cnt), 32'd3);
        reset_L = 1'b0;
        #1;
        check_reset_state("rst_mid");
        @(posedge clk_32f);
        #1;
        check_reset_state("rst_hold");
        reset_L = 1'b1;
        model_reset();

        // Full preamble again, then data.
        repeat (4) send_byte(1'b0, 8'h00, 1'b0);
        send_byte(1'b1, 8'hC3, 1'b0);
        send_byte(1'b0, 8'h00, 1'b0);

        chk("q_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_paralelo_serie
